// File: rtl/codec_init_seq_pkg.sv
// codec_init_pkg: shared types and the SSM2603 power-up register table.
//   state_e      - sequencer state encoding
//   entry_t      - one init write: {reg_addr[6:0], data[8:0]}
//   INIT_TABLE   - 16-slot table; slots 0..10 hold the SSM2603 bring-up
//                  writes in issue order, unused slots are zero
//   entry_byte0/1 - split an entry into the two I2C payload bytes
// The table holds eleven writes (R15 .. R9). The default NUM_REGS of 10
// stops after R8. Build with NUM_REGS=11 to also issue the R9 "active" write.
package codec_init_pkg;

  typedef enum logic [2:0] {
    ST_DELAY = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_e;

  typedef struct packed {
    logic [6:0] reg_addr;
    logic [8:0] data;
  } entry_t;

  localparam int TABLE_SLOTS = 16;

  localparam entry_t INIT_TABLE [0:TABLE_SLOTS-1] = '{
    '{reg_addr: 7'd15, data: 9'h000},  // software reset
    '{reg_addr: 7'd6,  data: 9'h030},  // power management
    '{reg_addr: 7'd0,  data: 9'h017},  // left line-in
    '{reg_addr: 7'd1,  data: 9'h017},  // right line-in
    '{reg_addr: 7'd2,  data: 9'h079},  // left headphone
    '{reg_addr: 7'd3,  data: 9'h079},  // right headphone
    '{reg_addr: 7'd4,  data: 9'h012},  // analog audio path
    '{reg_addr: 7'd5,  data: 9'h000},  // digital audio path
    '{reg_addr: 7'd7,  data: 9'h00A},  // I2S, 24-bit
    '{reg_addr: 7'd8,  data: 9'h000},  // sampling rate
    '{reg_addr: 7'd9,  data: 9'h001},  // activate digital core
    '{reg_addr: 7'd0,  data: 9'h000},
    '{reg_addr: 7'd0,  data: 9'h000},
    '{reg_addr: 7'd0,  data: 9'h000},
    '{reg_addr: 7'd0,  data: 9'h000},
    '{reg_addr: 7'd0,  data: 9'h000}
  };

  // First payload byte: register address followed by data bit 8.
  function automatic logic [7:0] entry_byte0(input entry_t e);
    return {e.reg_addr, e.data[8]};
  endfunction

  // Second payload byte: low eight data bits.
  function automatic logic [7:0] entry_byte1(input entry_t e);
    return e.data[7:0];
  endfunction

endpackage

// File: rtl/codec_init_seq_if.sv
// codec_init_seq_if: write-request handshake between the init sequencer and
// an I2C master engine.
//   txn_valid/txn_ready - request handshake (sequencer -> engine)
//   txn_dev             - 7-bit device address
//   txn_byte0/txn_byte1 - payload bytes
//   txn_done/txn_nack   - completion pulse and NACK flag (engine -> sequencer)
// Modport master: the request issuer (sequencer). Modport slave: the engine.
interface codec_init_seq_if;
  logic       txn_valid;
  logic       txn_ready;
  logic [6:0] txn_dev;
  logic [7:0] txn_byte0;
  logic [7:0] txn_byte1;
  logic       txn_done;
  logic       txn_nack;

  modport master (
    output txn_valid, txn_dev, txn_byte0, txn_byte1,
    input  txn_ready, txn_done, txn_nack
  );

  modport slave (
    input  txn_valid, txn_dev, txn_byte0, txn_byte1,
    output txn_ready, txn_done, txn_nack
  );
endinterface

// File: rtl/codec_init_seq_rom.sv
// codec_init_rom: combinational index -> init entry lookup.
//   NUM_REGS - number of live entries. Indices at or above it read as zero.
//   index    - 4-bit table index
//   entry    - {reg_addr, data} of that slot
module codec_init_rom
  import codec_init_pkg::*;
#(
  parameter int NUM_REGS = 10
) (
  input  logic [3:0] index,
  output entry_t     entry
);

  // Table lookup; out-of-range slots return an all-zero entry.
  always_comb begin
    entry = '0;
    if (int'(index) < NUM_REGS) begin
      entry = INIT_TABLE[index];
    end else begin
      entry = '0;
    end
  end

endmodule

// File: rtl/codec_init_seq.sv
// codec_init_seq: power-up register initialisation sequencer for an audio
// codec on I2C. Waits PWR_DELAY cycles after reset, then writes each init
// table entry through the request interface. Ends in DONE, or in FAIL on a
// NACK.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - re-run request, honoured only in DONE or FAIL
//   bus         - codec_init_seq_if.master request/completion handshake
//   busy        - high in every state except DONE and FAIL
//   init_done   - high while in DONE
//   init_fail   - high while in FAIL
//   fail_index  - table index of the entry that failed
// Optional build macro: CODEC_INIT_RETRY_EN. When it is defined, a NACKed
// entry is retried up to three times before FAIL.
module codec_init_seq
  import codec_init_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter logic [31:0] PWR_DELAY = 32'd1_000_000,
  parameter int          NUM_REGS  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  codec_init_seq_if.master       bus,
  output logic                   busy,
  output logic                   init_done,
  output logic                   init_fail,
  output logic [3:0]             fail_index
);

  localparam logic [2:0] S_DELAY = 3'(ST_DELAY);
  localparam logic [2:0] S_ISSUE = 3'(ST_ISSUE);
  localparam logic [2:0] S_WAIT  = 3'(ST_WAIT);
  localparam logic [2:0] S_NEXT  = 3'(ST_NEXT);
  localparam logic [2:0] S_DONE  = 3'(ST_DONE);
  localparam logic [2:0] S_FAIL  = 3'(ST_FAIL);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic [3:0]  idx_r;
  logic [3:0]  idx_s;
  logic [31:0] delay_cnt_r;
  logic        restart_s;
  logic        fail_enter_s;
  entry_t      entry_s;

`ifdef CODEC_INIT_RETRY_EN
  logic [1:0]  retry_r;
  logic [1:0]  retry_s;
`endif

  // Entry for the index the sequencer will hold after this edge. Outputs
  // are loaded from it so the payload is ready when txn_valid rises.
  codec_init_rom #(
    .NUM_REGS (NUM_REGS)
  ) u_rom (
    .index (idx_s),
    .entry (entry_s)
  );

  // Next-state, next-index and retry-count decode.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
`ifdef CODEC_INIT_RETRY_EN
    retry_s = retry_r;
`endif
    case (state_r)
      S_DELAY: begin
        // Counter starts at 0 on the first post-reset cycle; leaving when it
        // reads PWR_DELAY puts the first txn_valid PWR_DELAY+1 edges out.
        if (delay_cnt_r == PWR_DELAY) begin
          state_s = S_ISSUE;
        end else begin
          state_s = S_DELAY;
        end
      end
      S_ISSUE: begin
        if (bus.txn_valid && bus.txn_ready) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (bus.txn_done && !bus.txn_nack) begin
          state_s = S_NEXT;
        end else if (bus.txn_done) begin
`ifdef CODEC_INIT_RETRY_EN
          if (retry_r == 2'd3) begin
            state_s = S_FAIL;
          end else begin
            retry_s = retry_r + 2'd1;
            state_s = S_ISSUE;
          end
`else
          state_s = S_FAIL;
`endif
        end else begin
          state_s = S_WAIT;
        end
      end
      S_NEXT: begin
`ifdef CODEC_INIT_RETRY_EN
        retry_s = 2'd0;
`endif
        // Index saturates at the last entry; it never wraps.
        if (idx_r == LAST_IDX) begin
          state_s = S_DONE;
        end else begin
          idx_s   = idx_r + 4'd1;
          state_s = S_ISSUE;
        end
      end
      S_DONE, S_FAIL: begin
        if (start) begin
          idx_s   = 4'd0;
`ifdef CODEC_INIT_RETRY_EN
          retry_s = 2'd0;
`endif
          state_s = S_ISSUE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = S_DELAY;
        idx_s   = 4'd0;
      end
    endcase
  end

  assign restart_s    = ((state_r == S_DONE) || (state_r == S_FAIL)) && start;
  assign fail_enter_s = (state_s == S_FAIL) && (state_r != S_FAIL);

  // State, index and power-up delay counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_DELAY;
      idx_r       <= 4'd0;
      delay_cnt_r <= 32'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if ((state_r == S_DELAY) && (state_s == S_DELAY)) begin
        delay_cnt_r <= delay_cnt_r + 32'd1;
      end else begin
        delay_cnt_r <= 32'd0;
      end
    end
  end

`ifdef CODEC_INIT_RETRY_EN
  // Per-entry NACK retry counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      retry_r <= 2'd0;
    end else begin
      retry_r <= retry_s;
    end
  end
`endif

  // Registered request outputs, loaded from the next state so txn_valid
  // tracks ISSUE exactly and the payload stays frozen while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.txn_valid <= 1'b0;
      bus.txn_dev   <= 7'd0;
      bus.txn_byte0 <= 8'd0;
      bus.txn_byte1 <= 8'd0;
    end else begin
      bus.txn_valid <= (state_s == S_ISSUE);
      if (state_s == S_ISSUE) begin
        bus.txn_dev   <= DEV_ADDR;
        bus.txn_byte0 <= entry_byte0(entry_s);
        bus.txn_byte1 <= entry_byte1(entry_s);
      end else begin
        bus.txn_dev   <= bus.txn_dev;
        bus.txn_byte0 <= bus.txn_byte0;
        bus.txn_byte1 <= bus.txn_byte1;
      end
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      init_done  <= 1'b0;
      init_fail  <= 1'b0;
      fail_index <= 4'd0;
    end else begin
      busy      <= (state_s != S_DONE) && (state_s != S_FAIL);
      init_done <= (state_s == S_DONE);
      init_fail <= (state_s == S_FAIL);
      if (fail_enter_s) begin
        fail_index <= idx_r;
      end else if (restart_s) begin
        fail_index <= 4'd0;
      end else begin
        fail_index <= fail_index;
      end
    end
  end

endmodule
